// File: rtl/btn_pkg.sv
// Register offsets and counter width shared by the button peripheral and its users.
package btn_pkg;

    localparam logic [1:0] BTN_REG_STATE = 2'd0;
    localparam logic [1:0] BTN_REG_RISE  = 2'd1;
    localparam logic [1:0] BTN_REG_FALL  = 2'd2;
    localparam logic [1:0] BTN_REG_CNT   = 2'd3;

    localparam int BTN_CNT_W = 16;

endpackage

// File: rtl/input_debouncer.sv
// Single-line synchronizer and debouncer: the stable level follows the synchronized
// input only after it has differed for DEBOUNCE_CYCLES consecutive cycles.
module input_debouncer #(
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw_i,
    output logic stable_o,
    output logic rise_o,
    output logic fall_o
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic          meta;
    logic          sync;
    logic          stable;
    logic [CW-1:0] count;
    logic          settle;

    // The counter reaching DEBOUNCE_CYCLES this edge is the moment stable flips.
    assign settle = (sync != stable) && (count == CW'(DEBOUNCE_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta   <= 1'b0;
            sync   <= 1'b0;
            stable <= 1'b0;
            count  <= '0;
        end else begin
            meta <= raw_i;
            sync <= meta;
            if (sync == stable) begin
                count <= '0;
            end else if (settle) begin
                stable <= sync;
                count  <= '0;
            end else begin
                count <= count + CW'(1);
            end
        end
    end

    assign stable_o = stable;
    assign rise_o   = settle & sync;
    assign fall_o   = settle & ~sync;

endmodule

// File: rtl/button_peripheral.sv
// Memory-mapped button input block: debounced state, sticky edge flags and a press
// counter exposed as four 32-bit registers with a combinational read path.
module button_peripheral
    import btn_pkg::*;
#(
    parameter int NUM_INPUTS      = 8,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  rd_en_i,
    input  logic                  wr_en_i,
    input  logic [31:0]           addr_i,
    input  logic [31:0]           data_i,
    output logic [31:0]           data_o,
    input  logic [NUM_INPUTS-1:0] buttons_i
);

    logic [NUM_INPUTS-1:0] stable;
    logic [NUM_INPUTS-1:0] rise_ev;
    logic [NUM_INPUTS-1:0] fall_ev;
    logic [NUM_INPUTS-1:0] rise_flags;
    logic [NUM_INPUTS-1:0] fall_flags;
    logic [NUM_INPUTS-1:0] clear_mask;
    logic [BTN_CNT_W-1:0]  press_cnt;
    logic [BTN_CNT_W-1:0]  rise_total;
    logic [1:0]            sel;
    logic                  wr_rise;
    logic                  wr_fall;
    logic                  wr_cnt;
    logic                  unused_bits;

    for (genvar i = 0; i < NUM_INPUTS; i++) begin : g_line
        input_debouncer #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debouncer (
            .clk      (clk),
            .rst_n    (rst_n),
            .raw_i    (buttons_i[i]),
            .stable_o (stable[i]),
            .rise_o   (rise_ev[i]),
            .fall_o   (fall_ev[i])
        );
    end

    assign sel         = addr_i[3:2];
    assign clear_mask  = data_i[NUM_INPUTS-1:0];
    assign wr_rise     = wr_en_i && (sel == BTN_REG_RISE);
    assign wr_fall     = wr_en_i && (sel == BTN_REG_FALL);
    assign wr_cnt      = wr_en_i && (sel == BTN_REG_CNT);
    assign unused_bits = ^{addr_i[31:4], addr_i[1:0], data_i};

    // Several lines can rise together, so the counter advances by their population count.
    always_comb begin
        rise_total = '0;
        for (int i = 0; i < NUM_INPUTS; i++) begin
            rise_total = rise_total + BTN_CNT_W'(rise_ev[i]);
        end
    end

    // Clear is applied before new events so a coincident edge always survives.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rise_flags <= '0;
            fall_flags <= '0;
            press_cnt  <= '0;
        end else begin
            rise_flags <= (rise_flags & ~(wr_rise ? clear_mask : '0)) | rise_ev;
            fall_flags <= (fall_flags & ~(wr_fall ? clear_mask : '0)) | fall_ev;
            press_cnt  <= (wr_cnt ? '0 : press_cnt) + rise_total;
        end
    end

    always_comb begin
        data_o = 32'h0;
        if (rd_en_i) begin
            case (sel)
                BTN_REG_STATE: data_o = 32'(stable);
                BTN_REG_RISE:  data_o = 32'(rise_flags);
                BTN_REG_FALL:  data_o = 32'(fall_flags);
                default:       data_o = 32'(press_cnt);
            endcase
        end
    end

endmodule
